// File: rtl/frame_sched.sv
// Double-buffered frame scheduler. It arbitrates two producers round-robin into a back
// buffer and swaps the back buffer to the displayed front buffer on qualifying frame_sync edges.
module frame_sched #(
  parameter int unsigned NPIX        = 35,
  parameter int unsigned HOLD_FRAMES = 4
) (
  input  logic            CLOCK_50,
  input  logic            rst_n,
  input  logic            frame_sync,
  input  logic            a_valid,
  input  logic [NPIX-1:0] a_frame,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [NPIX-1:0] b_frame,
  output logic            b_ready,
  input  logic            blank,
  output logic [NPIX-1:0] ens,
  output logic            owner,
  output logic            swap_pulse
);

  typedef enum logic {EMPTY, FULL} state_e;

  localparam logic [7:0] HOLD_MAX = 8'(HOLD_FRAMES - 1);

  state_e          state_q, state_d;
  logic [NPIX-1:0] front_q, front_d;
  logic [NPIX-1:0] back_q, back_d;
  logic            back_owner_q, back_owner_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic [7:0]      hold_cnt_q, hold_cnt_d;
  logic            swap_pulse_q, swap_pulse_d;

  logic grant_a, grant_b, swap;

  always_comb begin
    grant_a = (state_q == EMPTY) && a_valid && (!b_valid || last_grant_q);
    grant_b = (state_q == EMPTY) && b_valid && !grant_a;
    swap    = (state_q == FULL) && frame_sync && (hold_cnt_q == HOLD_MAX);

    state_d      = state_q;
    front_d      = front_q;
    back_d       = back_q;
    back_owner_d = back_owner_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    hold_cnt_d   = hold_cnt_q;
    swap_pulse_d = swap;

    if (swap) begin
      front_d    = back_q;
      owner_d    = back_owner_q;
      state_d    = EMPTY;
      hold_cnt_d = '0;
    end else if (frame_sync && (hold_cnt_q != HOLD_MAX)) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end

    // Grants only happen while EMPTY, so they never collide with a swap.
    if (grant_a || grant_b) begin
      back_d       = grant_a ? a_frame : b_frame;
      back_owner_d = grant_b;
      last_grant_d = grant_b;
      state_d      = FULL;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      front_q      <= '0;
      back_q       <= '0;
      back_owner_q <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      hold_cnt_q   <= HOLD_MAX;
      swap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      front_q      <= front_d;
      back_q       <= back_d;
      back_owner_q <= back_owner_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      hold_cnt_q   <= hold_cnt_d;
      swap_pulse_q <= swap_pulse_d;
    end
  end

  assign a_ready    = grant_a;
  assign b_ready    = grant_b;
  assign ens        = blank ? '0 : front_q;
  assign owner      = owner_q;
  assign swap_pulse = swap_pulse_q;

endmodule

// File: tb/tb_frame_sched.sv
// Bench for frame_sched. Two instances (HOLD_FRAMES 4 and 1) with independent stimulus,
// each compared every cycle against a behavioural model of the display and pending frame.
module tb_frame_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fs[2], a_valid[2], b_valid[2], blank[2];
  logic [34:0] a_frame[2], b_frame[2], ens[2];
  logic        a_ready[2], b_ready[2], owner[2], swap_pulse[2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_sched #(.NPIX(35), .HOLD_FRAMES(4)) u_h4 (
    .CLOCK_50(clk), .rst_n(rst_n), .frame_sync(fs[0]),
    .a_valid(a_valid[0]), .a_frame(a_frame[0]), .a_ready(a_ready[0]),
    .b_valid(b_valid[0]), .b_frame(b_frame[0]), .b_ready(b_ready[0]),
    .blank(blank[0]), .ens(ens[0]), .owner(owner[0]), .swap_pulse(swap_pulse[0]));

  frame_sched #(.NPIX(35), .HOLD_FRAMES(1)) u_h1 (
    .CLOCK_50(clk), .rst_n(rst_n), .frame_sync(fs[1]),
    .a_valid(a_valid[1]), .a_frame(a_frame[1]), .a_ready(a_ready[1]),
    .b_valid(b_valid[1]), .b_frame(b_frame[1]), .b_ready(b_ready[1]),
    .blank(blank[1]), .ens(ens[1]), .owner(owner[1]), .swap_pulse(swap_pulse[1]));

  // Reference model: the frame on display, at most one pending frame, and scans since last swap.
  int          hcfg[2] = '{4, 1};
  logic [34:0] m_front[2], m_pdata[2];
  logic        m_owner[2], m_pend[2], m_psrc[2], m_last[2], m_swp[2];
  int          m_shown[2];
  logic        xa[2], xb[2], sw[2], keep[2];

  task automatic chk(input string tag, input int idx, input logic [34:0] got, input logic [34:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s[%0d] observed %h expected %h", tag, idx, got, exp);
    end
  endtask

  function automatic logic [34:0] rnd35();
    logic [34:0] v;
    v = {3'($urandom_range(7)), 32'($urandom)};
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_front[i] = '0; m_pdata[i] = '0; m_owner[i] = 1'b0; m_pend[i] = 1'b0;
      m_psrc[i] = 1'b0; m_last[i] = 1'b1; m_swp[i] = 1'b0;
      m_shown[i] = hcfg[i] - 1;
      xa[i] = 1'b0; xb[i] = 1'b0; sw[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) chk("rst_ens", i, ens[i], '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_owner", i, 35'(owner[i]), '0);
      chk("rst_swap", i, 35'(swap_pulse[i]), '0);
    end
    rst_n = 1'b1;
  endtask

  task automatic step();
    logic ea, eb;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      ea = !m_pend[i] && a_valid[i] && (!b_valid[i] || m_last[i]);
      eb = !m_pend[i] && b_valid[i] && !ea;
      chk("a_ready", i, 35'(a_ready[i]), 35'(ea));
      chk("b_ready", i, 35'(b_ready[i]), 35'(eb));
      chk("ready_excl", i, 35'(a_ready[i] && b_ready[i]), '0);
      chk("ens", i, ens[i], blank[i] ? 35'h0 : m_front[i]);
      chk("owner", i, 35'(owner[i]), 35'(m_owner[i]));
      chk("swap_pulse", i, 35'(swap_pulse[i]), 35'(m_swp[i]));
      xa[i] = ea; xb[i] = eb;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      sw[i] = m_pend[i] && fs[i] && (m_shown[i] >= hcfg[i] - 1);
      m_swp[i] = sw[i];
      if (sw[i]) begin
        m_front[i] = m_pdata[i]; m_owner[i] = m_psrc[i]; m_pend[i] = 1'b0; m_shown[i] = 0;
      end else if (fs[i] && m_shown[i] < 1000) begin
        m_shown[i]++;
      end
      if (xa[i]) begin
        m_pend[i] = 1'b1; m_pdata[i] = a_frame[i]; m_psrc[i] = 1'b0; m_last[i] = 1'b0;
      end else if (xb[i]) begin
        m_pend[i] = 1'b1; m_pdata[i] = b_frame[i]; m_psrc[i] = 1'b1; m_last[i] = 1'b1;
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      if (xa[i]) begin
        if (keep[i]) a_frame[i] = rnd35(); else a_valid[i] = 1'b0;
      end
      if (xb[i]) begin
        if (keep[i]) b_frame[i] = rnd35(); else b_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic pulse(input int i);
    fs[i] = 1'b1;
    step();
    fs[i] = 1'b0;
  endtask

  int nswap, change_at, nacc;
  logic order[$];

  initial begin
    for (int i = 0; i < 2; i++) begin
      fs[i] = 1'b0; a_valid[i] = 1'b0; b_valid[i] = 1'b0; blank[i] = 1'b0;
      a_frame[i] = '0; b_frame[i] = '0; keep[i] = 1'b0;
    end
    model_reset();
    #2;
    do_reset();

    // 1: first frame after reset swaps on the first frame_sync
    a_valid[0] = 1'b1; a_frame[0] = 35'h7_FFFF_FFFF;
    step();
    chk("t1_accept", 0, 35'(xa[0]), 35'h1);
    steps(9);
    pulse(0);
    chk("t1_ens", 0, ens[0], 35'h7_FFFF_FFFF);
    chk("t1_owner", 0, 35'(owner[0]), '0);
    chk("t1_swap", 0, 35'(swap_pulse[0]), 35'h1);
    steps(2);

    // 2: second frame waits a full hold period
    do_reset();
    a_valid[0] = 1'b1; a_frame[0] = 35'h1;
    step();
    a_valid[0] = 1'b1; a_frame[0] = 35'h2;
    nswap = 0; change_at = 0;
    for (int p = 1; p <= 10; p++) begin
      pulse(0);
      if (sw[0]) nswap++;
      if (change_at == 0 && ens[0] === 35'h2) change_at = p;
      steps(3);
    end
    chk("t2_swaps", 0, 35'(nswap), 35'd2);
    chk("t2_change_at", 0, 35'(change_at), 35'd5);
    chk("t2_ens", 0, ens[0], 35'h2);

    // 3: both producers always valid, HOLD_FRAMES=1 -> alternating grants
    do_reset();
    keep[1] = 1'b1;
    a_valid[1] = 1'b1; a_frame[1] = rnd35();
    b_valid[1] = 1'b1; b_frame[1] = rnd35();
    nswap = 0;
    for (int c = 0; c < 100 && nswap < 6; c++) begin
      fs[1] = (c % 3 == 2);
      step();
      if (xa[1]) order.push_back(1'b0);
      if (xb[1]) order.push_back(1'b1);
      if (sw[1]) nswap++;
    end
    fs[1] = 1'b0;
    chk("t3_swaps", 1, 35'(nswap), 35'd6);
    for (int k = 0; k < 6; k++)
      chk("t3_order", k, 35'((k < order.size()) ? order[k] : 1'bx), 35'(k % 2));
    keep[1] = 1'b0; a_valid[1] = 1'b0; b_valid[1] = 1'b0;
    steps(2);

    // 4: transfer coinciding with frame_sync while EMPTY
    do_reset();
    a_valid[0] = 1'b1; a_frame[0] = 35'h4_0000_0001;
    fs[0] = 1'b1;
    step();
    fs[0] = 1'b0;
    chk("t4_accept", 0, 35'(xa[0]), 35'h1);
    chk("t4_noswap", 0, 35'(sw[0]), '0);
    steps(3);
    pulse(0);
    chk("t4_swap", 0, 35'(swap_pulse[0]), 35'h1);
    chk("t4_ens", 0, ens[0], 35'h4_0000_0001);

    // 5: blank across a swap
    do_reset();
    blank[0] = 1'b1;
    a_valid[0] = 1'b1; a_frame[0] = 35'h5_5555_5555;
    steps(2);
    pulse(0);
    chk("t5_swap", 0, 35'(swap_pulse[0]), 35'h1);
    chk("t5_dark", 0, ens[0], '0);
    blank[0] = 1'b0;
    #1;
    chk("t5_unblank", 0, ens[0], 35'h5_5555_5555);
    steps(2);

    // 6: reset while FULL discards the pending frame
    do_reset();
    a_valid[0] = 1'b1; a_frame[0] = 35'h1;
    step();
    pulse(0);
    a_valid[0] = 1'b1; a_frame[0] = 35'h3;
    steps(2);
    chk("t6_front", 0, ens[0], 35'h1);
    do_reset();
    a_valid[0] = 1'b1; a_frame[0] = 35'h10;
    b_valid[0] = 1'b1; b_frame[0] = 35'h20;
    step();
    chk("t6_a_first", 0, 35'(xa[0]), 35'h1);
    for (int c = 0; c < 30; c++) begin
      fs[0] = (c % 4 == 0);
      step();
      chk("t6_no3", 0, 35'(ens[0] === 35'h3), '0);
    end
    fs[0] = 1'b0;

    // Random traffic on both instances
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!a_valid[i] && $urandom_range(2) == 0) begin a_valid[i] = 1'b1; a_frame[i] = rnd35(); end
        if (!b_valid[i] && $urandom_range(2) == 0) begin b_valid[i] = 1'b1; b_frame[i] = rnd35(); end
        fs[i] = ($urandom_range(4) == 0);
        blank[i] = ($urandom_range(7) == 0);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_sched.md
Name: frame_sched

Overview:
- Double-buffered frame scheduler that feeds the 35-bit point-enable vector of the 5x7 LED matrix scanner.
- Two frame producers (A, B) hand 35-bit frames in over valid/ready; the block arbitrates between them round-robin and loads the winner into a back buffer.
- The back buffer swaps into the displayed front buffer only on a scanner frame boundary, and only after the current frame has been shown for at least HOLD_FRAMES full scans. This prevents tearing and sets the animation rate.

Parameters:
- NPIX, 35, frame width in points; bit k = point k, row-major, 7 points per row.
- HOLD_FRAMES, 4, minimum scan frames each displayed frame is held; legal range 1..255.

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- frame_sync  in  1  one-cycle pulse, synchronous to CLOCK_50, in the cycle the scanner wraps point 34 to point 0.
- a_valid  in  1  producer A frame valid.
- a_frame  in  NPIX  producer A frame data.
- a_ready  out  1  producer A transfer accepted this cycle.
- b_valid  in  1  producer B frame valid.
- b_frame  in  NPIX  producer B frame data.
- b_ready  out  1  producer B transfer accepted this cycle.
- blank  in  1  force display dark; buffers are unaffected.
- ens  out  NPIX  enable vector to the scanner.
- owner  out  1  source of the displayed frame: 0 = A, 1 = B.
- swap_pulse  out  1  registered; high for the one cycle after a swap edge.

Behaviour:
- Reset values: ens=0, owner=0, swap_pulse=0, a_ready=b_ready=0.
- Reset internals: front=0, back=0, state=EMPTY, last_grant=B (A wins the first tie), hold_cnt=HOLD_FRAMES-1 (saturated).
- State EMPTY (back free):
  - Grant A if a_valid and (!b_valid or last_grant==B).
  - Otherwise grant B if b_valid.
  - Ready outputs are combinational: the granted side's ready=1, the other's=0. A transfer is valid&&ready.
  - On transfer: back<=granted frame, back_owner<=granted id, last_grant<=granted id, state<=FULL.
- State FULL: a_ready=b_ready=0; valids are ignored and producers hold their data.
- Swap condition: state==FULL && frame_sync && hold_cnt==HOLD_FRAMES-1.
- On swap edge:
  - front<=back, owner<=back_owner, state<=EMPTY, hold_cnt<=0.
  - swap_pulse=1 for the following cycle.
- frame_sync without a swap: hold_cnt<=min(hold_cnt+1, HOLD_FRAMES-1). The counter saturates and never wraps.
- With HOLD_FRAMES=1, a loaded frame swaps at the next frame_sync.
- ens = blank ? 0 : front (combinational AND).
  - blank does not stall swaps or the hold counter.
  - Deasserting blank shows the current front immediately.
- Simultaneous events:
  - Transfer and frame_sync in the same cycle while EMPTY: the load occurs; no swap that cycle, since the state was EMPTY. The hold count still increments.
  - Swap cycle: ready stays 0. The earliest next transfer is the cycle after the swap.
  - Both valids high while EMPTY: exactly one ready is asserted, never both.
- Latency:
  - Transfer to display: at least 1 cycle. It is the first qualifying frame_sync edge after the load, so the frame appears on ens the cycle after that edge.
  - A frame held by a producer while the block is FULL waits one swap period.
- Reset mid-operation: any pending back frame is discarded, the display goes dark, and arbitration returns to A-first.
- Widths: the hold counter is 8 bits; HOLD_FRAMES-1 is compared at 8 bits. No arithmetic is done on frame data.

Test Plan:
1. Reset, a_valid=1, a_frame=35'h7_FFFF_FFFF, first frame_sync 10 cycles later -> a_ready=1 for one cycle. ens=35'h7_FFFF_FFFF, owner=0 and swap_pulse=1 in the cycle after the frame_sync edge.
2. HOLD_FRAMES=4; load a frame with 35'h1, then immediately offer 35'h2 from A, 10 frame_sync pulses -> 35'h2 is accepted after the first swap. ens changes from 35'h1 to 35'h2 only on the 4th frame_sync after the first swap; total swap_pulse count = 2.
3. a_valid and b_valid both held high continuously, HOLD_FRAMES=1, 6 swaps -> accept order A,B,A,B,A,B. owner alternates 0,1,0,...; a_ready and b_ready are never high together.
4. EMPTY state, transfer in the same cycle as frame_sync -> no swap that cycle, state=FULL. The swap occurs on the next frame_sync (HOLD saturated).
5. blank=1 across a swap of 35'h5_5555_5555 -> ens=0 throughout and swap_pulse still fires. Releasing blank gives ens=35'h5_5555_5555 in the same cycle.
6. rst_n low while FULL with a pending 35'h3 and front=35'h1 -> ens=0 immediately (async). After release, 35'h3 is never displayed and A wins the first tie.
